// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage with a single IF/ID holding slot. It walks a small
//   instruction memory four bytes at a time, stalls on decode back-pressure,
//   accepts branch/jump redirects, halts after the last memory word, and locks
//   up in an error state on a misaligned redirect target.
//
// Parameters
//   RESET_PC   first fetch address after reset
//   MEM_BYTES  instruction memory size in bytes (multiple of 4)
//
// Ports
//   clock             rising-edge clock
//   reset             asynchronous, active-low reset
//   PC                fetch address, straight from a register
//   Instruction_Code  memory word for PC (combinational memory)
//   redirect_valid    redirect request
//   redirect_pc       redirect target
//   id_ready          decode accepts the slot this cycle
//   id_valid          slot holds an instruction
//   id_instr, id_pc   slot contents
//   halted            state is HALT
//   misalign_err      state is ERROR (sticky until reset)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 24
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] PC,
    input  logic [31:0] Instruction_Code,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        halted,
    output logic        misalign_err
);

    localparam logic [31:0] MEM_END = 32'(MEM_BYTES);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HALT  = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc_reg;
    logic [31:0] pc_inc;
    logic        slot_free;

    assign PC        = pc_reg;
    assign pc_inc    = pc_reg + 32'd4;
    assign slot_free = !id_valid || id_ready;

    // halted / misalign_err are registered alongside the state so they always
    // mirror it exactly without any output decode.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_FETCH;
            pc_reg       <= RESET_PC;
            id_valid     <= 1'b0;
            id_instr     <= 32'h0;
            id_pc        <= 32'h0;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            case (state)
                S_FETCH, S_HALT: begin
                    if (redirect_valid) begin
                        // Redirect wins over capture/stall and flushes the slot.
                        id_valid <= 1'b0;
                        pc_reg   <= redirect_pc;
                        if (redirect_pc[1:0] != 2'b00) begin
                            state        <= S_ERROR;
                            halted       <= 1'b0;
                            misalign_err <= 1'b1;
                        end else if (redirect_pc >= MEM_END) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else begin
                            state  <= S_FETCH;
                            halted <= 1'b0;
                        end
                    end else if (state == S_FETCH) begin
                        if (slot_free) begin
                            id_instr <= Instruction_Code;
                            id_pc    <= pc_reg;
                            id_valid <= 1'b1;
                            pc_reg   <= pc_inc;
                            // Capturing the last word parks the fetcher.
                            if (pc_inc == MEM_END) begin
                                state  <= S_HALT;
                                halted <= 1'b1;
                            end
                        end
                        // otherwise stall: everything holds
                    end else if (id_ready) begin
                        id_valid <= 1'b0;
                    end
                end
                default: begin
                    // ERROR: redirects ignored, PC frozen, only drain the slot.
                    if (id_ready) id_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] PC;
    logic [31:0] Instruction_Code;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        halted;
    logic        misalign_err;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    fetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(24)) dut (
        .clock            (clock),
        .reset            (reset),
        .PC               (PC),
        .Instruction_Code (Instruction_Code),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .id_ready         (id_ready),
        .id_valid         (id_valid),
        .id_instr         (id_instr),
        .id_pc            (id_pc),
        .halted           (halted),
        .misalign_err     (misalign_err)
    );

    // 6-word instruction memory, read combinationally
    localparam logic [31:0] M0 = 32'h00940333, M1 = 32'h412983b3, M2 = 32'h00f768b3,
                            M3 = 32'h40b50533, M4 = 32'h00c5f5b3, M5 = 32'h01bdaf33;
    logic [31:0] mem [0:5];
    initial begin
        mem[0] = M0; mem[1] = M1; mem[2] = M2;
        mem[3] = M3; mem[4] = M4; mem[5] = M5;
    end
    assign Instruction_Code = (PC < 32'd24) ? mem[PC[4:2]] : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [31:0] ei,
                           input logic [31:0] ep, input logic [31:0] epc,
                           input logic eh, input logic ee);
        chk({tag, ".id_valid"},     {31'h0, id_valid},     {31'h0, ev});
        chk({tag, ".id_instr"},     id_instr,              ei);
        chk({tag, ".id_pc"},        id_pc,                 ep);
        chk({tag, ".PC"},           PC,                    epc);
        chk({tag, ".halted"},       {31'h0, halted},       {31'h0, eh});
        chk({tag, ".misalign_err"}, {31'h0, misalign_err}, {31'h0, ee});
    endtask

    // one cycle of stimulus followed by the state expected after the edge
    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        logic [31:0] epc;
        logic        eh;
        logic        ee;
    } vec_t;

    vec_t vt[$];

    task automatic addv(input logic rdy, input logic rv, input logic [31:0] rpc,
                        input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                        input logic [31:0] epc, input logic eh, input logic ee);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ev = ev; v.ei = ei;
        v.ep = ep; v.epc = epc; v.eh = eh; v.ee = ee;
        vt.push_back(v);
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];

    initial begin
        //   rdy rv  rpc     ev  instr id_pc  PC     h  e
        addv(1, 0, 32'h0,  1, M0, 32'd0,  32'd4,  0, 0);  // first edge after reset
        addv(1, 0, 32'h0,  1, M1, 32'd4,  32'd8,  0, 0);
        addv(0, 0, 32'h0,  1, M1, 32'd4,  32'd8,  0, 0);  // stall x3
        addv(0, 0, 32'h0,  1, M1, 32'd4,  32'd8,  0, 0);
        addv(0, 0, 32'h0,  1, M1, 32'd4,  32'd8,  0, 0);
        addv(1, 0, 32'h0,  1, M2, 32'd8,  32'd12, 0, 0);
        addv(1, 0, 32'h0,  1, M3, 32'd12, 32'd16, 0, 0);
        addv(1, 0, 32'h0,  1, M4, 32'd16, 32'd20, 0, 0);
        addv(1, 0, 32'h0,  1, M5, 32'd20, 32'd24, 1, 0);  // last word -> HALT
        addv(1, 0, 32'h0,  0, M5, 32'd20, 32'd24, 1, 0);  // drained, PC holds
        addv(1, 0, 32'h0,  0, M5, 32'd20, 32'd24, 1, 0);
        addv(0, 1, 32'h4,  0, M5, 32'd20, 32'd4,  0, 0);  // redirect out of HALT
        addv(1, 0, 32'h0,  1, M1, 32'd4,  32'd8,  0, 0);
        addv(0, 1, 32'h8,  0, M1, 32'd4,  32'd8,  0, 0);  // redirect during stall
        addv(0, 0, 32'h0,  1, M2, 32'd8,  32'd12, 0, 0);
        addv(0, 0, 32'h0,  1, M2, 32'd8,  32'd12, 0, 0);
        addv(0, 1, 32'h40, 0, M2, 32'd8,  32'h40, 1, 0);  // aligned, past end -> HALT
        addv(1, 0, 32'h0,  0, M2, 32'd8,  32'h40, 1, 0);
        addv(0, 1, 32'h0,  0, M2, 32'd8,  32'd0,  0, 0);
        addv(1, 0, 32'h0,  1, M0, 32'd0,  32'd4,  0, 0);
        addv(0, 1, 32'h6,  0, M0, 32'd0,  32'd6,  0, 1);  // misaligned -> ERROR
        addv(1, 1, 32'h0,  0, M0, 32'd0,  32'd6,  0, 1);  // ignored in ERROR
        addv(1, 0, 32'h0,  0, M0, 32'd0,  32'd6,  0, 1);

        // reset state, before and across a clock edge
        #2;
        chk_all("reset_pre", 0, 32'h0, 32'h0, 32'h0, 0, 0);
        #5;
        chk_all("reset_edge", 0, 32'h0, 32'h0, 32'h0, 0, 0);
        #5;          // t=12: release between edges
        reset = 1'b1;

        foreach (vt[i]) begin
            id_ready       = vt[i].rdy;
            redirect_valid = vt[i].rv;
            redirect_pc    = vt[i].rpc;
            @(posedge clock); #1;
            chk_all($sformatf("vec%0d", i), vt[i].ev, vt[i].ei, vt[i].ep,
                    vt[i].epc, vt[i].eh, vt[i].ee);
        end

        // reset clears ERROR immediately, no clock edge needed
        redirect_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("err_async_clear", {31'h0, misalign_err}, 32'h0);
        chk("err_async_pc", PC, 32'h0);

        // reset during a stall with a redirect pending discards both
        #1;
        reset    = 1'b1;
        id_ready = 1'b0;
        @(posedge clock); #1;
        chk_all("rst_seq_cap", 1, M0, 32'd0, 32'd4, 0, 0);
        @(posedge clock); #1;
        chk_all("rst_seq_stall", 1, M0, 32'd0, 32'd4, 0, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        #2;
        reset = 1'b0;
        #1;
        chk_all("rst_seq_async", 0, 32'h0, 32'h0, 32'h0, 0, 0);
        redirect_valid = 1'b0;
        #1;
        reset    = 1'b1;
        id_ready = 1'b1;
        @(posedge clock); #1;
        chk_all("rst_seq_after", 1, M0, 32'd0, 32'd4, 0, 0);

        // scoreboard run: random back-pressure, every word must come out in order
        reset = 1'b0;
        #2;
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            e.pc    = 32'(i * 4);
            e.instr = mem[i];
            sb.push_back(e);
        end
        reset = 1'b1;
        begin
            int cyc = 0;
            while (sb.size() > 0 && cyc < 300) begin
                id_ready = 1'($urandom_range(0, 1));
                if (id_valid && id_ready) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_pc", id_pc, e.pc);
                    chk("sb_instr", id_instr, e.instr);
                end
                @(posedge clock); #1;
                cyc++;
            end
            chk("sb_drained", 32'(sb.size()), 32'd0);
        end
        chk("sb_halted", {31'h0, halted}, 32'h1);
        chk("sb_valid_after", {31'h0, id_valid}, 32'h0);
        chk("sb_pc_end", PC, 32'd24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
